// File: rtl/block_interleaver.sv
// block_interleaver: 802.11a-style two-permutation block interleaver.
// Serial coded bits are scattered into one of two ping-pong banks at the
// permuted address j(k); a full bank is then streamed out linearly, one bit
// per cycle, with the block length latched when its first bit arrived.
module block_interleaver #(
    parameter int MAXBITS = 288
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       data_in,
    input  logic       inputValid,
    output logic       data_out,
    output logic       outputValid
);

    typedef enum logic {
        IDLE,
        STREAM
    } ReadState;

    // Coded bits per OFDM symbol for each modulation
    function automatic logic [8:0] cbpsOf(input logic [1:0] m);
        case (m)
            2'd0:    return 9'd48;
            2'd1:    return 9'd96;
            2'd2:    return 9'd192;
            default: return 9'd288;
        endcase
    endfunction

    logic [MAXBITS-1:0] bankMem [2];
    logic [1:0]         bankMode [2];
    logic [1:0]         full;

    logic [8:0] k;
    logic [1:0] latchedMode;
    logic       writeBank;

    logic [1:0] effMode;
    logic [8:0] modeLen;
    logic [8:0] colDepth;
    logic [8:0] iIdx;
    logic [8:0] fIdx;
    logic [9:0] tIdx;
    logic [8:0] jIdx;

    ReadState   state;
    ReadState   stateNext;
    logic [8:0] rIdx;
    logic [8:0] rNext;
    logic       readBank;
    logic       readBankNext;
    logic       otherBank;
    logic [8:0] readLen;
    logic       releaseBank;
    logic       validNext;
    logic       bitNext;

    // Write address: the live mode only matters for the very first bit of a block
    always_comb begin
        effMode  = (k == 9'd0) ? mode : latchedMode;
        modeLen  = cbpsOf(effMode);
        colDepth = modeLen >> 4;
        iIdx     = 9'(colDepth * {5'd0, k[3:0]}) + {4'd0, k[8:4]};
        fIdx     = iIdx / colDepth;
        tIdx     = {1'b0, iIdx} + {1'b0, modeLen} - {1'b0, fIdx};
        case (effMode)
            2'd2:    jIdx = {iIdx[8:1], tIdx[0]};
            2'd3:    jIdx = iIdx - (iIdx % 9'd3) + 9'(tIdx % 10'd3);
            default: jIdx = iIdx;
        endcase
    end

    // Write side: index, mode latch, bank swap and full flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k           <= 9'd0;
            latchedMode <= 2'd0;
            writeBank   <= 1'b0;
            full        <= 2'b00;
            bankMode[0] <= 2'd0;
            bankMode[1] <= 2'd0;
        end else begin
            if (releaseBank) begin
                full[readBank] <= 1'b0;
            end
            if (inputValid) begin
                if (k == 9'd0) begin
                    latchedMode <= mode;
                end
                if (k == modeLen - 9'd1) begin
                    k                   <= 9'd0;
                    writeBank           <= ~writeBank;
                    full[writeBank]     <= 1'b1;
                    bankMode[writeBank] <= effMode;
                end else begin
                    k <= k + 9'd1;
                end
            end
        end
    end

    // Bank storage is not reset; stale contents are never read without a full flag
    always_ff @(posedge clock) begin
        if (inputValid) begin
            bankMem[writeBank][jIdx] <= data_in;
        end
    end

    // Read FSM next state: start on a full bank, wrap straight into the other bank if ready
    always_comb begin
        stateNext    = state;
        rNext        = rIdx;
        readBankNext = readBank;
        releaseBank  = 1'b0;
        validNext    = 1'b0;
        otherBank    = ~readBank;
        readLen      = cbpsOf(bankMode[readBank]);
        case (state)
            IDLE: begin
                if (full[readBank]) begin
                    stateNext = STREAM;
                    rNext     = 9'd0;
                    validNext = 1'b1;
                end
            end
            STREAM: begin
                if (rIdx == readLen - 9'd1) begin
                    releaseBank  = 1'b1;
                    readBankNext = otherBank;
                    rNext        = 9'd0;
                    if (full[otherBank]) begin
                        validNext = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    rNext     = rIdx + 9'd1;
                    validNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
        bitNext = validNext ? bankMem[readBankNext][rNext] : 1'b0;
    end

    // Read FSM state and registered serial output
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rIdx        <= 9'd0;
            readBank    <= 1'b0;
            data_out    <= 1'b0;
            outputValid <= 1'b0;
        end else begin
            state       <= stateNext;
            rIdx        <= rNext;
            readBank    <= readBankNext;
            data_out    <= bitNext;
            outputValid <= validNext;
        end
    end

endmodule

// File: tb/tb_block_interleaver.sv
// tb_block_interleaver: directed checks of the block interleaver permutation,
// ping-pong streaming, mode latching and asynchronous reset behaviour.
module tb_block_interleaver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       data_in = 1'b0;
    logic       inputValid = 1'b0;
    logic       data_out;
    logic       outputValid;

    int   compareCount = 0;
    int   failCount = 0;
    int   cycleCount = 0;
    int   lastCapture = 0;
    logic outQ[$];
    int   cycQ[$];

    block_interleaver #(.MAXBITS(288)) dut (
        .clock(clock),
        .reset(reset),
        .mode(mode),
        .data_in(data_in),
        .inputValid(inputValid),
        .data_out(data_out),
        .outputValid(outputValid)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clock = ~clock;

    // Output address of input bit k, straight from the interleaver formulas
    function automatic int permIndex(int k, int n);
        int nbpsc;
        int s;
        int i;
        case (n)
            48:      nbpsc = 1;
            96:      nbpsc = 2;
            192:     nbpsc = 4;
            default: nbpsc = 6;
        endcase
        s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
        i = (n / 16) * (k % 16) + k / 16;
        return s * (i / s) + ((i + n - (16 * i) / n) % s);
    endfunction

    function automatic logic [287:0] permute(logic [287:0] bits, int n);
        logic [287:0] v = '0;
        for (int k = 0; k < n; k++) v[permIndex(k, n)] = bits[k];
        return v;
    endfunction

    function automatic logic [287:0] randomBits(int n);
        logic [287:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [287:0] packOut();
        logic [287:0] v = '0;
        for (int i = 0; i < outQ.size() && i < 288; i++) v[i] = outQ[i];
        return v;
    endfunction

    // One clock cycle: drive at negedge, capture on posedge, sample at next negedge
    task automatic applyStimulus(input logic v, input logic d, input logic [1:0] m);
        inputValid = v;
        data_in    = d;
        mode       = m;
        @(posedge clock);
        @(negedge clock);
        cycleCount++;
        if (outputValid === 1'b1) begin
            outQ.push_back(data_out);
            cycQ.push_back(cycleCount);
        end
    endtask

    task automatic sendBlock(input int n, input logic [1:0] mEarly, input logic [1:0] mLate,
                             input logic [287:0] bits, input bit gapped);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, bits[k], (k < 20) ? mEarly : mLate);
            if (k == n - 1) lastCapture = cycleCount;
            if (gapped) applyStimulus(1'b0, 1'b1, mLate);
        end
    endtask

    task automatic drain(input int cycles, input logic [1:0] m);
        for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 1'b0, m);
    endtask

    task automatic clearCapture();
        outQ.delete();
        cycQ.delete();
    endtask

    task automatic test_reset();
        inputValid = 1'b1;
        data_in    = 1'b1;
        mode       = 2'd3;
        #2 reset = 1'b0;
        #1;
        compareCount++;
        if (outputValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_valid: got %b expected 0", outputValid);
        end
        compareCount++;
        if (data_out !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_data: got %b expected 0", data_out);
        end
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 2'd3);
        applyStimulus(1'b1, 1'b1, 2'd3);
        compareCount++;
        if (outputValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_hold_valid: got %b expected 0", outputValid);
        end
        compareCount++;
        if (data_out !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_hold_data: got %b expected 0", data_out);
        end
        reset = 1'b1;
        clearCapture();
        drain(20, 2'd0);
        compareCount++;
        if (outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL reset_idle_out: got %0d bits expected 0", outQ.size());
        end
    endtask

    task automatic test_bpsk();
        logic [287:0] bits;
        logic [287:0] expBits;
        logic [287:0] got;
        int startCycle;
        int span;
        clearCapture();
        bits = '0;
        bits[1] = 1'b1;
        expBits = '0;
        expBits[3] = 1'b1;
        sendBlock(48, 2'd0, 2'd0, bits, 1'b0);
        drain(60, 2'd0);
        got = packOut();
        startCycle = (cycQ.size() > 0) ? cycQ[0] : -1;
        span = (cycQ.size() > 0) ? cycQ[cycQ.size()-1] - cycQ[0] + 1 : 0;
        compareCount++;
        if (outQ.size() !== 48) begin
            failCount++;
            $display("[TB] FAIL bpsk_k1_count: got %0d expected 48", outQ.size());
        end
        compareCount++;
        if (startCycle !== lastCapture + 1) begin
            failCount++;
            $display("[TB] FAIL bpsk_k1_start: got cycle %0d expected %0d", startCycle, lastCapture + 1);
        end
        compareCount++;
        if (span !== 48) begin
            failCount++;
            $display("[TB] FAIL bpsk_k1_span: got %0d expected 48", span);
        end
        compareCount++;
        if (got !== expBits) begin
            failCount++;
            $display("[TB] FAIL bpsk_k1_bits: got %h expected %h", got, expBits);
        end
        clearCapture();
        bits = '0;
        bits[16] = 1'b1;
        expBits = '0;
        expBits[1] = 1'b1;
        sendBlock(48, 2'd0, 2'd0, bits, 1'b0);
        drain(60, 2'd0);
        got = packOut();
        compareCount++;
        if (got !== expBits || outQ.size() !== 48) begin
            failCount++;
            $display("[TB] FAIL bpsk_k16_bits: got %h (%0d bits) expected %h (48 bits)", got, outQ.size(), expBits);
        end
    endtask

    task automatic test_qam();
        logic [287:0] bits;
        logic [287:0] expBits;
        logic [287:0] got;
        clearCapture();
        bits = '0;
        bits[1] = 1'b1;
        expBits = '0;
        expBits[13] = 1'b1;
        sendBlock(192, 2'd2, 2'd2, bits, 1'b0);
        drain(210, 2'd2);
        got = packOut();
        compareCount++;
        if (got !== expBits || outQ.size() !== 192) begin
            failCount++;
            $display("[TB] FAIL qam16_k1_bits: got %h (%0d bits) expected %h (192 bits)", got, outQ.size(), expBits);
        end
        clearCapture();
        expBits = '0;
        expBits[20] = 1'b1;
        sendBlock(288, 2'd3, 2'd3, bits, 1'b0);
        drain(300, 2'd3);
        got = packOut();
        compareCount++;
        if (got !== expBits || outQ.size() !== 288) begin
            failCount++;
            $display("[TB] FAIL qam64_k1_bits: got %h (%0d bits) expected %h (288 bits)", got, outQ.size(), expBits);
        end
    endtask

    task automatic test_back_to_back();
        logic [287:0] blk [3];
        logic [287:0] tmp;
        logic [287:0] expBits;
        logic [287:0] got;
        int firstEnd = 0;
        int startCycle;
        int span;
        clearCapture();
        expBits = '0;
        for (int b = 0; b < 3; b++) begin
            blk[b] = randomBits(96);
            tmp = permute(blk[b], 96);
            for (int r = 0; r < 96; r++) expBits[b * 96 + r] = tmp[r];
        end
        for (int b = 0; b < 3; b++) begin
            sendBlock(96, 2'd1, 2'd1, blk[b], 1'b0);
            if (b == 0) firstEnd = lastCapture;
        end
        drain(120, 2'd1);
        got = packOut();
        startCycle = (cycQ.size() > 0) ? cycQ[0] : -1;
        span = (cycQ.size() > 0) ? cycQ[cycQ.size()-1] - cycQ[0] + 1 : 0;
        compareCount++;
        if (outQ.size() !== 288) begin
            failCount++;
            $display("[TB] FAIL b2b_count: got %0d expected 288", outQ.size());
        end
        compareCount++;
        if (startCycle !== firstEnd + 1) begin
            failCount++;
            $display("[TB] FAIL b2b_start: got cycle %0d expected %0d", startCycle, firstEnd + 1);
        end
        compareCount++;
        if (span !== 288) begin
            failCount++;
            $display("[TB] FAIL b2b_span: got %0d expected 288", span);
        end
        compareCount++;
        if (got !== expBits) begin
            failCount++;
            $display("[TB] FAIL b2b_bits: got %h expected %h", got, expBits);
        end
    endtask

    task automatic test_gapped_input();
        logic [287:0] bits;
        logic [287:0] expBits;
        logic [287:0] got;
        int startCycle;
        int span;
        clearCapture();
        bits = randomBits(288);
        expBits = permute(bits, 288);
        sendBlock(288, 2'd3, 2'd3, bits, 1'b1);
        drain(300, 2'd3);
        got = packOut();
        startCycle = (cycQ.size() > 0) ? cycQ[0] : -1;
        span = (cycQ.size() > 0) ? cycQ[cycQ.size()-1] - cycQ[0] + 1 : 0;
        compareCount++;
        if (outQ.size() !== 288) begin
            failCount++;
            $display("[TB] FAIL gapped_count: got %0d expected 288", outQ.size());
        end
        compareCount++;
        if (startCycle !== lastCapture + 1) begin
            failCount++;
            $display("[TB] FAIL gapped_start: got cycle %0d expected %0d", startCycle, lastCapture + 1);
        end
        compareCount++;
        if (span !== 288) begin
            failCount++;
            $display("[TB] FAIL gapped_span: got %0d expected 288", span);
        end
        compareCount++;
        if (got !== expBits) begin
            failCount++;
            $display("[TB] FAIL gapped_bits: got %h expected %h", got, expBits);
        end
    endtask

    task automatic test_mode_change();
        logic [287:0] bits;
        logic [287:0] expBits;
        logic [287:0] got;
        clearCapture();
        bits = randomBits(48);
        expBits = permute(bits, 48);
        sendBlock(48, 2'd0, 2'd3, bits, 1'b0);
        drain(60, 2'd3);
        got = packOut();
        compareCount++;
        if (outQ.size() !== 48) begin
            failCount++;
            $display("[TB] FAIL modechg_bpsk_count: got %0d expected 48", outQ.size());
        end
        compareCount++;
        if (got !== expBits) begin
            failCount++;
            $display("[TB] FAIL modechg_bpsk_bits: got %h expected %h", got, expBits);
        end
        clearCapture();
        bits = randomBits(288);
        expBits = permute(bits, 288);
        sendBlock(288, 2'd3, 2'd3, bits, 1'b0);
        drain(300, 2'd3);
        got = packOut();
        compareCount++;
        if (outQ.size() !== 288) begin
            failCount++;
            $display("[TB] FAIL modechg_qam64_count: got %0d expected 288", outQ.size());
        end
        compareCount++;
        if (got !== expBits) begin
            failCount++;
            $display("[TB] FAIL modechg_qam64_bits: got %h expected %h", got, expBits);
        end
    endtask

    task automatic test_reset_midstream();
        logic [287:0] bits;
        logic [287:0] bitsB;
        logic [287:0] expBits;
        logic [287:0] got;
        // Partial 16-QAM block interrupted at k=100
        clearCapture();
        bits = randomBits(192);
        sendBlock(100, 2'd2, 2'd2, bits, 1'b0);
        #2 reset = 1'b0;
        #1;
        compareCount++;
        if (outputValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midblk_reset_valid: got %b expected 0", outputValid);
        end
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 2'd2);
        applyStimulus(1'b1, 1'b1, 2'd2);
        reset = 1'b1;
        clearCapture();
        drain(250, 2'd2);
        compareCount++;
        if (outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL midblk_stale: got %0d bits expected 0", outQ.size());
        end
        clearCapture();
        bits = randomBits(192);
        expBits = permute(bits, 192);
        sendBlock(192, 2'd2, 2'd2, bits, 1'b0);
        drain(210, 2'd2);
        got = packOut();
        compareCount++;
        if (got !== expBits || outQ.size() !== 192) begin
            failCount++;
            $display("[TB] FAIL midblk_fresh_bits: got %h (%0d bits) expected %h (192 bits)", got, outQ.size(), expBits);
        end
        // Reset during a read burst while a second block is pending
        clearCapture();
        bits = randomBits(192);
        bitsB = randomBits(192);
        sendBlock(192, 2'd2, 2'd2, bits, 1'b0);
        sendBlock(192, 2'd2, 2'd2, bitsB, 1'b0);
        compareCount++;
        if (outputValid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL burst_active: got %b expected 1", outputValid);
        end
        #2 reset = 1'b0;
        #1;
        compareCount++;
        if (outputValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL burst_async_valid: got %b expected 0", outputValid);
        end
        compareCount++;
        if (data_out !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL burst_async_data: got %b expected 0", data_out);
        end
        @(negedge clock);
        applyStimulus(1'b0, 1'b0, 2'd2);
        applyStimulus(1'b0, 1'b0, 2'd2);
        reset = 1'b1;
        clearCapture();
        drain(250, 2'd2);
        compareCount++;
        if (outQ.size() !== 0) begin
            failCount++;
            $display("[TB] FAIL burst_pending_stale: got %0d bits expected 0", outQ.size());
        end
        clearCapture();
        bits = randomBits(192);
        expBits = permute(bits, 192);
        sendBlock(192, 2'd2, 2'd2, bits, 1'b0);
        drain(210, 2'd2);
        got = packOut();
        compareCount++;
        if (got !== expBits || outQ.size() !== 192) begin
            failCount++;
            $display("[TB] FAIL burst_fresh_bits: got %h (%0d bits) expected %h (192 bits)", got, outQ.size(), expBits);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_bpsk();
        test_qam();
        test_back_to_back();
        test_gapped_input();
        test_mode_change();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    // Watchdog so a stuck run still terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
